// File: rtl/memory_utils.sv
// Shared types and constants for the PDP-8 memory access sequencer.
package memory_utils;

  typedef logic [11:0] word;

  localparam logic DATA_READ         = 1'b0;
  localparam logic INSTRUCTION_FETCH = 1'b1;

  localparam logic [1:0] KIND_FETCH = 2'd0;
  localparam logic [1:0] KIND_READ  = 2'd1;
  localparam logic [1:0] KIND_WRITE = 2'd2;
  localparam logic [1:0] KIND_RSVD  = 2'd3;

  localparam word AUTO_INDEX_LO = 12'o0010;
  localparam word AUTO_INDEX_HI = 12'o0017;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH_RD = 4'd1,
    IND_RD   = 4'd2,
    IND_CAP  = 4'd3,
    AUTO_WR  = 4'd4,
    OP_RD    = 4'd5,
    OP_CAP   = 4'd6,
    OP_WR    = 4'd7,
    DONE     = 4'd8
  } state_e;

  // Pointer as it ends up after an optional auto-index bump (wraps mod 4096).
  function automatic word next_ptr(input word ptr, input logic bump);
    return ptr + {11'd0, bump};
  endfunction

endpackage

// File: rtl/mem_access_sequencer_ea_calc.sv
// Direct effective address (page zero / current page) and auto-index detection.
// The auto-index flag is only produced when AUTO_INDEX_EN is defined.
module ea_calc
  import memory_utils::*;
(
  input  logic [11:0] pc,
  input  logic [11:0] instr,
  output logic [11:0] direct_addr,
  output logic        is_auto_index
);

  logic unused_bits_s;

  assign direct_addr = instr[7] ? {pc[11:7], instr[6:0]} : {5'd0, instr[6:0]};

`ifdef AUTO_INDEX_EN
  assign is_auto_index = (direct_addr >= AUTO_INDEX_LO) && (direct_addr <= AUTO_INDEX_HI);
`else
  assign is_auto_index = 1'b0;
`endif

  // Page-offset bits of the PC and opcode/I bits are consumed elsewhere.
  assign unused_bits_s = ^{pc[6:0], instr[11:8]};

endmodule

// File: rtl/mem_access_sequencer.sv
// PDP-8 memory access sequencer: fetch, operand read/write with indirect
// addressing. Auto-index for 0010-0017 is enabled by defining AUTO_INDEX_EN.
module mem_access_sequencer
  import memory_utils::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [11:0] req_pc,
  input  logic [11:0] req_instr,
  input  logic [11:0] req_wdata,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_read_type,
  output logic        mem_write_enable,
  input  logic [11:0] mem_read_data,
  output logic        rsp_valid,
  output logic [11:0] rsp_data,
  output logic [11:0] rsp_ea
);

  state_e state_q, state_d;
  word    mem_address_q, mem_address_d;
  word    mem_write_data_q, mem_write_data_d;
  logic   mem_read_enable_q, mem_read_enable_d;
  logic   mem_read_type_q, mem_read_type_d;
  logic   mem_write_enable_q, mem_write_enable_d;
  logic   rsp_valid_q, rsp_valid_d;
  word    rsp_data_q, rsp_data_d;
  word    rsp_ea_q, rsp_ea_d;
  logic   is_write_q, is_write_d;
  logic   auto_q, auto_d;
  word    dir_addr_q, dir_addr_d;
  word    ea_q, ea_d;
  word    wdata_q, wdata_d;

  word    dir_addr_s;
  logic   is_auto_s;
  word    ptr_s;

  ea_calc u_ea_calc (
    .pc            (req_pc),
    .instr         (req_instr),
    .direct_addr   (dir_addr_s),
    .is_auto_index (is_auto_s)
  );

  assign ptr_s     = next_ptr(mem_read_data, auto_q);
  assign req_ready = (state_q == IDLE) && reset_n;

  // Next-state and next-output logic; strobes default low so each lasts one cycle.
  always_comb begin
    state_d            = state_q;
    mem_address_d      = mem_address_q;
    mem_write_data_d   = mem_write_data_q;
    mem_read_enable_d  = 1'b0;
    mem_read_type_d    = DATA_READ;
    mem_write_enable_d = 1'b0;
    rsp_valid_d        = 1'b0;
    rsp_data_d         = rsp_data_q;
    rsp_ea_d           = rsp_ea_q;
    is_write_d         = is_write_q;
    auto_d             = auto_q;
    dir_addr_d         = dir_addr_q;
    ea_d               = ea_q;
    wdata_d            = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_write_d = (req_kind == KIND_WRITE);
          auto_d     = is_auto_s;
          dir_addr_d = dir_addr_s;
          wdata_d    = req_wdata;
          if (req_kind == KIND_FETCH) begin
            ea_d              = req_pc;
            mem_address_d     = req_pc;
            mem_read_enable_d = 1'b1;
            mem_read_type_d   = INSTRUCTION_FETCH;
            state_d           = FETCH_RD;
          end else if (req_instr[8]) begin
            mem_address_d     = dir_addr_s;
            mem_read_enable_d = 1'b1;
            state_d           = IND_RD;
          end else if (req_kind == KIND_WRITE) begin
            ea_d               = dir_addr_s;
            mem_address_d      = dir_addr_s;
            mem_write_data_d   = req_wdata;
            mem_write_enable_d = 1'b1;
            state_d            = OP_WR;
          end else begin
            ea_d              = dir_addr_s;
            mem_address_d     = dir_addr_s;
            mem_read_enable_d = 1'b1;
            state_d           = OP_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FETCH_RD: state_d = OP_CAP;
      IND_RD:   state_d = IND_CAP;
      IND_CAP: begin
        ea_d = ptr_s;
        if (auto_q) begin
          mem_address_d      = dir_addr_q;
          mem_write_data_d   = ptr_s;
          mem_write_enable_d = 1'b1;
          state_d            = AUTO_WR;
        end else if (is_write_q) begin
          mem_address_d      = ptr_s;
          mem_write_data_d   = wdata_q;
          mem_write_enable_d = 1'b1;
          state_d            = OP_WR;
        end else begin
          mem_address_d     = ptr_s;
          mem_read_enable_d = 1'b1;
          state_d           = OP_RD;
        end
      end
      AUTO_WR: begin
        mem_address_d = ea_q;
        if (is_write_q) begin
          mem_write_data_d   = wdata_q;
          mem_write_enable_d = 1'b1;
          state_d            = OP_WR;
        end else begin
          mem_read_enable_d = 1'b1;
          state_d           = OP_RD;
        end
      end
      OP_RD: state_d = OP_CAP;
      OP_CAP: begin
        rsp_data_d  = mem_read_data;
        rsp_ea_d    = ea_q;
        rsp_valid_d = 1'b1;
        state_d     = DONE;
      end
      OP_WR: begin
        rsp_data_d  = wdata_q;
        rsp_ea_d    = ea_q;
        rsp_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any pending response or write-back.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= IDLE;
      mem_address_q      <= 12'd0;
      mem_write_data_q   <= 12'd0;
      mem_read_enable_q  <= 1'b0;
      mem_read_type_q    <= DATA_READ;
      mem_write_enable_q <= 1'b0;
      rsp_valid_q        <= 1'b0;
      rsp_data_q         <= 12'd0;
      rsp_ea_q           <= 12'd0;
      is_write_q         <= 1'b0;
      auto_q             <= 1'b0;
      dir_addr_q         <= 12'd0;
      ea_q               <= 12'd0;
      wdata_q            <= 12'd0;
    end else begin
      state_q            <= state_d;
      mem_address_q      <= mem_address_d;
      mem_write_data_q   <= mem_write_data_d;
      mem_read_enable_q  <= mem_read_enable_d;
      mem_read_type_q    <= mem_read_type_d;
      mem_write_enable_q <= mem_write_enable_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_data_q         <= rsp_data_d;
      rsp_ea_q           <= rsp_ea_d;
      is_write_q         <= is_write_d;
      auto_q             <= auto_d;
      dir_addr_q         <= dir_addr_d;
      ea_q               <= ea_d;
      wdata_q            <= wdata_d;
    end
  end

  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_write_data_q;
  assign mem_read_enable  = mem_read_enable_q;
  assign mem_read_type    = mem_read_type_q;
  assign mem_write_enable = mem_write_enable_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_ea           = rsp_ea_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: expected memory accesses and
// responses are queued at issue time and popped by negedge monitors.
module tb_mem_access_sequencer;
  import memory_utils::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [11:0] req_pc;
  logic [11:0] req_instr;
  logic [11:0] req_wdata;
  logic [11:0] mem_address;
  logic [11:0] mem_write_data;
  logic        mem_read_enable;
  logic        mem_read_type;
  logic        mem_write_enable;
  logic [11:0] mem_read_data = 12'd0;
  logic        rsp_valid;
  logic [11:0] rsp_data;
  logic [11:0] rsp_ea;

  logic [11:0] mem [0:4095];

  typedef struct {
    logic        we;
    logic        rtype;
    logic [11:0] addr;
    logic [11:0] data;
  } acc_t;

  typedef struct {
    logic [11:0] data;
    logic [11:0] ea;
    int          lat;
    time         t_acc;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_kind         (req_kind),
    .req_pc           (req_pc),
    .req_instr        (req_instr),
    .req_wdata        (req_wdata),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_enable  (mem_read_enable),
    .mem_read_type    (mem_read_type),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_ea           (rsp_ea)
  );

  // Memory controller model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_read_enable) mem_read_data <= mem[mem_address];
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %o expected %o at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Memory access monitor.
  always @(negedge clk) begin
    if (mem_read_enable || mem_write_enable) begin
      acc_t a;
      check("rd_wr_exclusive", {11'd0, mem_read_enable & mem_write_enable}, 12'd0);
      if (acc_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_access: got we=%0d addr=%o expected none at %0t",
                 mem_write_enable, mem_address, $time);
      end else begin
        a = acc_q.pop_front();
        check("acc_we", {11'd0, mem_write_enable}, {11'd0, a.we});
        check("acc_addr", mem_address, a.addr);
        if (a.we) check("acc_wdata", mem_write_data, a.data);
        else      check("acc_rtype", {11'd0, mem_read_type}, {11'd0, a.rtype});
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_t r;
      if (rsp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data=%o expected none at %0t", rsp_data, $time);
      end else begin
        r = rsp_q.pop_front();
        check("rsp_data", rsp_data, r.data);
        check("rsp_ea", rsp_ea, r.ea);
        check_int("rsp_latency", int'(($time - r.t_acc - 5) / 10) + 1, r.lat);
      end
    end
  end

  task automatic exp_rd(input logic [11:0] addr, input logic rtype);
    acc_t a;
    a.we = 1'b0; a.rtype = rtype; a.addr = addr; a.data = 12'd0;
    acc_q.push_back(a);
  endtask

  task automatic exp_wr(input logic [11:0] addr, input logic [11:0] data);
    acc_t a;
    a.we = 1'b1; a.rtype = DATA_READ; a.addr = addr; a.data = data;
    acc_q.push_back(a);
  endtask

  task automatic issue(input logic [1:0] kind, input logic [11:0] pc, input logic [11:0] instr,
                       input logic [11:0] wd, input bit want_rsp, input int lat,
                       input logic [11:0] edata, input logic [11:0] eea);
    int   n;
    rsp_t r;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 at %0t", $time);
      return;
    end
    req_valid = 1'b1;
    req_kind  = kind;
    req_pc    = pc;
    req_instr = instr;
    req_wdata = wd;
    @(posedge clk);
    r.t_acc = $time;
    #1 req_valid = 1'b0;
    if (want_rsp) begin
      r.data = edata; r.ea = eea; r.lat = lat;
      rsp_q.push_back(r);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((acc_q.size() != 0 || rsp_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (acc_q.size() != 0 || rsp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d accesses and %0d responses pending expected 0",
               acc_q.size(), rsp_q.size());
      acc_q.delete();
      rsp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] <= 12'd0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_kind  = KIND_FETCH;
    req_pc    = 12'd0;
    req_instr = 12'd0;
    req_wdata = 12'd0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", {11'd0, req_ready}, 12'd0);
    check("reset_mem_address", mem_address, 12'd0);
    check("reset_mem_write_data", mem_write_data, 12'd0);
    check("reset_strobes", {10'd0, mem_read_enable, mem_write_enable}, 12'd0);
    check("reset_read_type", {11'd0, mem_read_type}, {11'd0, DATA_READ});
    check("reset_rsp", {11'd0, rsp_valid}, 12'd0);
    check("reset_rsp_data", rsp_data, 12'd0);
    check("reset_rsp_ea", rsp_ea, 12'd0);
    reset_n = 1'b1;
    #1 check("ready_after_reset", {11'd0, req_ready}, 12'd1);

    mem[12'o0200] <= 12'o7001;
    mem[12'o0212] <= 12'o0042;
    mem[12'o0020] <= 12'o4000;
    mem[12'o4000] <= 12'o0055;
    mem[12'o0010] <= 12'o7777;
    mem[12'o0000] <= 12'o0123;
    mem[12'o7777] <= 12'o0555;
    mem[12'o0077] <= 12'o3333;
    mem[12'o0011] <= 12'o0100;
    mem[12'o0012] <= 12'o0500;

    // Instruction fetch.
    exp_rd(12'o0200, INSTRUCTION_FETCH);
    issue(KIND_FETCH, 12'o0200, 12'o0000, 12'd0, 1'b1, 3, 12'o7001, 12'o0200);
    drain();

    // Current-page direct read.
    exp_rd(12'o0212, DATA_READ);
    issue(KIND_READ, 12'o0345, 12'o1212, 12'd0, 1'b1, 3, 12'o0042, 12'o0212);
    drain();

    // Page-zero direct read with a high PC.
    exp_rd(12'o0077, DATA_READ);
    issue(KIND_READ, 12'o7600, 12'o1077, 12'd0, 1'b1, 3, 12'o3333, 12'o0077);
    drain();

    // Indirect read.
    exp_rd(12'o0020, DATA_READ);
    exp_rd(12'o4000, DATA_READ);
    issue(KIND_READ, 12'o0345, 12'o1420, 12'd0, 1'b1, 5, 12'o0055, 12'o4000);
    drain();

    // Indirect through an auto-index location holding 7777.
    exp_rd(12'o0010, DATA_READ);
`ifdef AUTO_INDEX_EN
    exp_wr(12'o0010, 12'o0000);
    exp_rd(12'o0000, DATA_READ);
    issue(KIND_READ, 12'o0345, 12'o1410, 12'd0, 1'b1, 6, 12'o0123, 12'o0000);
`else
    exp_rd(12'o7777, DATA_READ);
    issue(KIND_READ, 12'o0345, 12'o1410, 12'd0, 1'b1, 5, 12'o0555, 12'o7777);
`endif
    drain();

    // Direct write, then read it back.
    exp_wr(12'o0050, 12'o1234);
    issue(KIND_WRITE, 12'o0345, 12'o3050, 12'o1234, 1'b1, 2, 12'o1234, 12'o0050);
    drain();
    exp_rd(12'o0050, DATA_READ);
    issue(KIND_RSVD, 12'o0345, 12'o1050, 12'd0, 1'b1, 3, 12'o1234, 12'o0050);
    drain();

    // Indirect write.
    exp_rd(12'o0020, DATA_READ);
    exp_wr(12'o4000, 12'o0777);
    issue(KIND_WRITE, 12'o0345, 12'o3420, 12'o0777, 1'b1, 4, 12'o0777, 12'o4000);
    drain();

    // Indirect write through auto-index location 0011.
    exp_rd(12'o0011, DATA_READ);
`ifdef AUTO_INDEX_EN
    exp_wr(12'o0011, 12'o0101);
    exp_wr(12'o0101, 12'o2222);
    issue(KIND_WRITE, 12'o0345, 12'o3411, 12'o2222, 1'b1, 5, 12'o2222, 12'o0101);
`else
    exp_wr(12'o0100, 12'o2222);
    issue(KIND_WRITE, 12'o0345, 12'o3411, 12'o2222, 1'b1, 4, 12'o2222, 12'o0100);
`endif
    drain();

    // Reset while in IND_CAP: no write-back, no response.
    exp_rd(12'o0012, DATA_READ);
    issue(KIND_READ, 12'o0345, 12'o1412, 12'd0, 1'b0, 0, 12'd0, 12'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_strobes", {10'd0, mem_read_enable, mem_write_enable}, 12'd0);
    check("midreset_rsp_valid", {11'd0, rsp_valid}, 12'd0);
    check("midreset_req_ready", {11'd0, req_ready}, 12'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready_after_midreset", {11'd0, req_ready}, 12'd1);
    drain();

    // Pointer location must be untouched after the abandoned request.
    exp_rd(12'o0012, DATA_READ);
    issue(KIND_READ, 12'o0345, 12'o1012, 12'd0, 1'b1, 3, 12'o0500, 12'o0012);
    drain();

    // Fetch back-to-back after a direct read.
    exp_rd(12'o0212, DATA_READ);
    issue(KIND_READ, 12'o0345, 12'o1212, 12'd0, 1'b1, 3, 12'o0042, 12'o0212);
    drain();
    exp_rd(12'o0200, INSTRUCTION_FETCH);
    issue(KIND_FETCH, 12'o0200, 12'o0000, 12'd0, 1'b1, 3, 12'o7001, 12'o0200);
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
